// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks pending register writes across the post-decode
// pipeline and produces forward selects, a decode stall, and issue/stall
// performance counters.
module hazard_scoreboard #(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned FWD_W    = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic             issue_wr_en,
    input  logic [4:0]       issue_wr_reg,
    input  logic             issue_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic [31:0]      issue_count,
    output logic [31:0]      stall_count
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    // Per-stage entry; v is only set for instructions that write a register.
    logic [STAGES:1]  v_q;
    logic [STAGES:1]  ld_q;
    logic [REG_W-1:0] dst_q [1:STAGES];

    logic [CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic haz_a;
    logic haz_b;

    // Youngest-match search per operand; scanning oldest to youngest lets the
    // lowest stage overwrite any older match.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = int'(STAGES); k >= 1; k--) begin
            if (uses_rs && (issue_rs != '0) && v_q[k] && (dst_q[k] != '0) &&
                (dst_q[k] == issue_rs)) begin
                fwd_a = FWD_W'(k);
                haz_a = ld_q[k] && (k < int'(LOAD_LAT));
            end
            if (uses_rt && (issue_rt != '0) && v_q[k] && (dst_q[k] != '0) &&
                (dst_q[k] == issue_rt)) begin
                fwd_b = FWD_W'(k);
                haz_b = ld_q[k] && (k < int'(LOAD_LAT));
            end
        end
    end

    // Decode control; flush suppresses both stall and fire.
    always_comb begin
        stall      = issue_valid && !flush && (haz_a || haz_b);
        issue_fire = issue_valid && !flush && !stall;
    end

    // Valid bits shift every cycle; stalls and flushes inject bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            for (int k = int'(STAGES); k >= 2; k--) begin
                v_q[k] <= v_q[k-1];
            end
            v_q[1] <= issue_fire && issue_wr_en;
        end
    end

    // Entry payload shifts alongside the valid bits; no reset needed.
    always_ff @(posedge clk) begin
        for (int k = int'(STAGES); k >= 2; k--) begin
            dst_q[k] <= dst_q[k-1];
            ld_q[k]  <= ld_q[k-1];
        end
        dst_q[1] <= issue_wr_reg;
        ld_q[1]  <= issue_is_load;
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue_fire && (issue_cnt_q != '1)) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign issue_count = issue_cnt_q;
    assign stall_count = stall_cnt_q;

endmodule
